hazard_controller: RTL
======================

# hazard_controller

Pipeline hazard controller for the 5-stage RISC-V core: generates PC/IF-ID/ID-EX write enables, IF-ID and ID-EX flushes, and the EX/MEM bubble, and owns the start/done handshake to the multi-cycle mul/div unit in EX. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve:
- load-use
- taken branch redirect
- multi-cycle EX occupancy

## Interface
- `MD_TIMEOUT`, default 64: maximum MD_WAIT cycles before a forced release.
- `CNT_W`, default 16: width of the stall performance counter.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  ID instruction actually reads rs1/rs2
- `ex_rd`  in  5  destination of the instruction in EX
- `ex_mem_read`  in  1  EX instruction is a load
- `ex_muldiv`  in  1  EX instruction is a multi-cycle mul/div
- `branch_taken`  in  1  branch/jump resolved taken in EX
- `muldiv_done`  in  1  mul/div result valid this cycle
- `muldiv_start`  out  1  one-cycle start pulse to the mul/div unit
- `pc_write`, `ifid_write`, `idex_write`  out  1 each  register enables
- `ifid_flush`, `idex_flush`  out  1 each  replace the register contents with a NOP on the next edge
- `exmem_bubble`  out  1  load a NOP into EX/MEM
- `md_timeout`  out  1  sticky flag: a mul/div was force-released
- `stall_count`  out  CNT_W  stalled-cycle counter

## Operation
- **FSM states:** RUN and MD_WAIT. `md_cnt` is an internal counter, ceil(log2(MD_TIMEOUT+1)) bits wide.
- **Load-use detection:**
  - `lu = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))`.
- **Default outputs:** all write enables 1; all flushes, `exmem_bubble` and `muldiv_start` 0.
- **RUN, priority order (highest first):**
  1. `ex_muldiv`:
     - `muldiv_start=1`.
     - `pc_write`, `ifid_write` and `idex_write` = 0.
     - `exmem_bubble=1`.
     - Next state MD_WAIT; `md_cnt<=0`.
  2. `branch_taken`:
     - `ifid_flush=1`, `idex_flush=1`.
     - `pc_write=1`, so the redirect target is loaded.
     - `lu` is ignored.
  3. `lu`:
     - `pc_write=0`, `ifid_write=0`.
     - `idex_flush=1`, inserting one bubble.
- **MD_WAIT, `muldiv_done=0` and `md_cnt<MD_TIMEOUT-1`:**
  - Hold the same outputs as the start cycle, except `muldiv_start=0`.
  - `md_cnt` increments.
- **MD_WAIT, `muldiv_done=1`:**
  - Default outputs (release); the EX/MEM register captures the result.
  - Next state RUN.
  - `branch_taken`, `lu` and `ex_muldiv` are not evaluated in this cycle.
- **MD_WAIT, `muldiv_done=0` and `md_cnt==MD_TIMEOUT-1`:**
  - Release identically to the done case.
  - Set `md_timeout<=1`; it stays set until reset.
- **Ignored inputs:** `muldiv_done` is ignored in RUN, including the start cycle.
- **`stall_count`:** increments by 1 on every non-reset cycle with `pc_write==0`; saturates at all-ones (no wrap).

## Timing
- Control outputs are combinational from the state and the inputs; state, `md_cnt`, `md_timeout` and `stall_count` update on the rising edge.
- **While `reset` is high:**
  - `pc_write`, `ifid_write`, `idex_write` and `exmem_bubble` = 0.
  - `ifid_flush=1`, `idex_flush=1`.
  - `muldiv_start=0`.
- **State after a reset edge:** RUN; `md_cnt`, `md_timeout` and `stall_count` all 0.
- **Reset mid-MD_WAIT:** returns to RUN with no release cycle and no timeout flag.
- **Load-use:** exactly 1 stall cycle.
- **Taken branch:** 2 flushed slots, no stall.
- **Mul/div with done arriving L cycles after the start pulse (L≥1):**
  - Pipeline held for exactly L cycles (start cycle + L-1 wait cycles); release in the done cycle.
  - `stall_count` advances by L.
- **Timeout:** release occurs in the cycle that is MD_TIMEOUT cycles after the start pulse.

## Configuration
- **`HAZARD_PERF_EN` defined:** the `stall_count` register and increment logic are present as described.
- **`HAZARD_PERF_EN` undefined:** `stall_count` is tied to 0 and no counter flops are synthesized; all other behaviour is identical.

## Test plan
- **Load-use:** `ex_mem_read=1`, `ex_rd=5`, `id_rs2=5`, `id_uses_rs2=1` for one cycle, then `ex_mem_read=0` -> that cycle `pc_write=0`, `ifid_write=0`, `idex_flush=1`; next cycle defaults; `stall_count=1`.
- **x0 and unused source:**
  - `ex_rd=0` matching `id_rs1=0` -> no stall.
  - `id_rs1=7` matching `ex_rd=7` with `id_uses_rs1=0` -> no stall.
- **Branch over load-use:** `branch_taken=1` together with a valid `lu` -> `ifid_flush=idex_flush=1`, `pc_write=1`, `ifid_write=1`.
- **Mul/div:** `ex_muldiv` held, `muldiv_done` pulsed 4 cycles after start ->
  - `muldiv_start` high for exactly 1 cycle.
  - `pc_write=0` for 4 cycles, `exmem_bubble=1` for 4 cycles.
  - Release in the done cycle; `stall_count=4`; no second start pulse.
- **Timeout:** with MD_TIMEOUT=8 and `muldiv_done` never asserted -> release 8 cycles after start; `md_timeout=1` from the next edge and stays set through later RUN cycles.
- **Reset mid-MD_WAIT:** `reset` asserted 2 cycles into MD_WAIT -> flush outputs high during reset; after reset RUN, `stall_count=0`, `md_timeout=0`. With `HAZARD_PERF_EN` undefined, `stall_count` reads 0 throughout.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller: load-use / branch / mul-div stall and flush control; HAZARD_PERF_EN adds the stall counter.
module hazard_controller #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_muldiv,
    input  logic             branch_taken,
    input  logic             muldiv_done,
    output logic             muldiv_start,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_count
);
    localparam int MW = $clog2(MD_TIMEOUT + 1);

    typedef enum logic {RUN, MD_WAIT} state_t;

    state_t        state, state_n;
    logic [MW-1:0] md_cnt;
    logic          lu, md_last, run, md_hold, br, lus;

    assign lu = ex_mem_read & (ex_rd != 5'd0) &
                ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    assign md_last = md_cnt == MW'(MD_TIMEOUT - 1);
    assign run     = state == RUN;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            md_cnt     <= '0;
            md_timeout <= 1'b0;
        end else begin
            state  <= state_n;
            md_cnt <= run ? '0 : md_cnt + MW'(1);
            if (!run && !muldiv_done && md_last)
                md_timeout <= 1'b1;
        end
    end

    always_comb begin
        state_n = run ? (ex_muldiv ? MD_WAIT : RUN) : ((muldiv_done | md_last) ? RUN : MD_WAIT);
    end

    // reset forces flushes and drops every enable, independent of state
    always_comb begin
        md_hold      = run ? ex_muldiv : !(muldiv_done | md_last);
        br           = run & !ex_muldiv & branch_taken;
        lus          = run & !ex_muldiv & !branch_taken & lu;
        muldiv_start = !reset & run & ex_muldiv;
        pc_write     = !reset & !md_hold & !lus;
        ifid_write   = !reset & !md_hold & !lus;
        idex_write   = !reset & !md_hold;
        exmem_bubble = !reset & md_hold;
        ifid_flush   = reset | br;
        idex_flush   = reset | br | lus;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= '0;
        else if (!pc_write && stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
    end
`else
    assign stall_count = '0;
`endif
endmodule
